// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM encoding, word geometry and the fault classifier used at accept.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  localparam logic [1:0] FLT_NONE     = 2'd0;
  localparam logic [1:0] FLT_MISALIGN = 2'd1;
  localparam logic [1:0] FLT_RANGE    = 2'd2;

  // Misalignment takes priority so a misaligned, out-of-range address reports one reason.
  function automatic logic [1:0] fault_of(input logic [31:0] addr,
                                          input int unsigned depth_words);
    if (addr[1:0] != 2'b00) return FLT_MISALIGN;
    if ({2'b00, addr[31:2]} >= depth_words) return FLT_RANGE;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, no reset on contents or read register.
// Latency: read data appears the cycle after re; never stalls.
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
    if (re) rdata_q <= mem_q[idx];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the memory stage: one request at a time, WAIT_CYCLES+1 to respond
// (faults respond next cycle); busy stalls the pipeline until the single-cycle response pulse.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned OFS = $clog2(WORD_BYTES);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          err_q, err_d;
  logic          rd_ok_q, rd_ok_d;

  logic          fault;
  logic          arr_we, arr_re;
  logic [AW-1:0] arr_idx;
  logic [31:0]   arr_wdata, arr_rdata;

  assign fault = (fault_of(req_addr, DEPTH_WORDS) != FLT_NONE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    err_d     = 1'b0;
    rd_ok_d   = 1'b0;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_idx   = idx_q;
    arr_wdata = wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          idx_d   = req_addr[OFS +: AW];
          wdata_d = req_wdata;
          cnt_d   = WAIT_INIT;
          if (fault) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end else if (WAIT_CYCLES == 0) begin
            // Zero wait states: the access happens on the accept edge itself.
            state_d   = ST_RESP;
            arr_idx   = req_addr[OFS +: AW];
            arr_wdata = req_wdata;
            arr_we    = req_write;
            arr_re    = ~req_write;
            rd_ok_d   = ~req_write;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
          arr_we  = wr_q;
          arr_re  = ~wr_q;
          rd_ok_d = ~wr_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // The read register is unreset, so it is qualified to keep store/fault/reset responses at zero.
  assign resp_rdata = rd_ok_q ? arr_rdata : 32'd0;
  assign resp_err   = err_q;
  assign resp_valid = (state_q == ST_RESP);
  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = ((state_q == ST_IDLE) && req_valid) || (state_q == ST_WAIT);

endmodule
